// File: rtl/sb_bus_pkg.sv
// Shared definitions for the SB_SPI system-bus arbiter: FSM encoding,
// SB_SPI register map and SPISR status bit positions.
package sb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // SB_SPI register addresses
  localparam logic [7:0] SPICR0  = 8'h08;
  localparam logic [7:0] SPICR1  = 8'h09;
  localparam logic [7:0] SPICR2  = 8'h0A;
  localparam logic [7:0] SPIBR   = 8'h0B;
  localparam logic [7:0] SPISR   = 8'h0C;
  localparam logic [7:0] SPITXDR = 8'h0D;
  localparam logic [7:0] SPIRXDR = 8'h0E;
  localparam logic [7:0] SPICSR  = 8'h0F;

  localparam int SPISR_RRDY = 3;
  localparam int SPISR_TRDY = 4;

  // Round-robin pick between two requesters: a lone request always wins,
  // a tie goes to whoever was not granted last. Returns the winner id.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

endpackage

// File: rtl/sb_arb_timer.sv
// GRANT-phase watchdog: counts consecutive cycles with run=1 and flags the
// cycle in which the TIMEOUT_CYCLES-th such cycle occurs.
module sb_arb_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) cnt <= '0;
    else       cnt <= run ? cnt + 1'b1 : '0;
  end

  assign expired = run && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sb_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the SB_SPI system bus.
// Optional GRANT watchdog enabled by defining SBARB_TIMEOUT_EN.
module sb_bus_arbiter
  import sb_bus_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              req0_stb,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_adr,
  input  logic [DATA_W-1:0] req0_dati,
  output logic              req0_ack,
  output logic [DATA_W-1:0] req0_dato,
  output logic              req0_err,
  input  logic              req1_stb,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_adr,
  input  logic [DATA_W-1:0] req1_dati,
  output logic              req1_ack,
  output logic [DATA_W-1:0] req1_dato,
  output logic              req1_err,
  output logic              sb_stb,
  output logic              sb_rw,
  output logic [ADDR_W-1:0] sb_adr,
  output logic [DATA_W-1:0] sb_dati,
  input  logic [DATA_W-1:0] sb_dato,
  input  logic              sb_ack,
  output logic              busy,
  output logic              grant_id
);

  arb_state_t state, state_nxt;
  logic       last_grant;
  logic       any_req;
  logic       winner;
  logic       timeout;
  logic       done;
  logic       abort;

  assign any_req = req0_stb | req1_stb;
  assign winner  = rr_pick(req0_stb, req1_stb, last_grant);
  assign done    = sb_ack | timeout;
  // A real ack in the same cycle as the watchdog firing takes precedence.
  assign abort   = timeout & ~sb_ack;

`ifdef SBARB_TIMEOUT_EN
  sb_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .run     (state == ST_GRANT),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next-state is assigned a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (any_req) state_nxt = ST_GRANT;
      ST_GRANT:   if (done)    state_nxt = ST_RELEASE;
      ST_RELEASE:              state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  // All outputs are flops; acks and error flags default to a single-cycle pulse.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sb_stb     <= 1'b0;
      sb_rw      <= 1'b0;
      sb_adr     <= '0;
      sb_dati    <= '0;
      req0_ack   <= 1'b0;
      req1_ack   <= 1'b0;
      req0_err   <= 1'b0;
      req1_err   <= 1'b0;
      req0_dato  <= '0;
      req1_dato  <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      req0_err <= 1'b0;
      req1_err <= 1'b0;
      busy     <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            sb_stb     <= 1'b1;
            sb_rw      <= winner ? req1_rw   : req0_rw;
            sb_adr     <= winner ? req1_adr  : req0_adr;
            sb_dati    <= winner ? req1_dati : req0_dati;
            grant_id   <= winner;
            last_grant <= winner;
          end
        end
        ST_GRANT: begin
          if (done) begin
            sb_stb <= 1'b0;
            if (grant_id) begin
              req1_ack <= 1'b1;
              req1_err <= abort;
              if (abort)       req1_dato <= '1;
              else if (!sb_rw) req1_dato <= sb_dato;
            end else begin
              req0_ack <= 1'b1;
              req0_err <= abort;
              if (abort)       req0_dato <= '1;
              else if (!sb_rw) req0_dato <= sb_dato;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
